dram_port_arbiter: RTL

- Shares the single-port data RAM (`dram`) between two requesters: the CPU data port (port 0) and a loader/DMA master (port 1).
- Sits in `system` between `cpu_0`'s data interface and `dram_0`.
- Serialises accesses with a bounded-burst priority scheme and returns read data with a fixed latency.
- Optionally decodes the CPU memory-mapped STDOUT/halt addresses.

---
 rtl/dram_arb_pkg.sv | 17 +
 rtl/dram_arb_pick.sv | 41 ++++
 rtl/dram_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DRAM port arbiter: FSM states, port indices
// and the memory-mapped STDOUT/halt addresses.
package dram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   localparam logic P_CPU = 1'b0;
   localparam logic P_DMA = 1'b1;

   localparam logic [23:0] STDOUT_ADDR = 24'hFFFFFE;
   localparam logic [23:0] HALT_ADDR   = 24'hFFFFFF;

endpackage

// File: rtl/dram_arb_pick.sv
// Winner selection between the CPU and DMA ports, plus the CPU burst
// counter that guarantees the DMA port a slot every MAX_CPU_BURST grants.
module dram_arb_pick
   import dram_arb_pkg::*;
#(
   parameter int MAX_CPU_BURST = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic clk_en,
   input  logic idle,
   input  logic p0_req,
   input  logic p1_req,
   input  logic halt,
   output logic any_req,
   output logic winner
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_CPU_BURST);

   logic [3:0] burst_cnt;
   logic       p0_eligible;

   assign p0_eligible = p0_req & ~halt;
   assign any_req     = p0_eligible | p1_req;
   assign winner      = (p1_req && (!p0_eligible || burst_cnt >= MAX_CNT)) ? P_DMA : P_CPU;

   // The count only tracks CPU grants that actually made the DMA port wait.
   always_ff @(posedge clk) begin
      if (rst) begin
         burst_cnt <= '0;
      end else if (clk_en && idle) begin
         if (!p1_req || winner == P_DMA) begin
            burst_cnt <= '0;
         end else begin
            burst_cnt <= burst_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the single-port data RAM between the CPU (port 0) and a loader/DMA
// master (port 1). Define DRAM_ARB_MMIO_EN to add the CPU STDOUT/halt decode.
module dram_port_arbiter
   import dram_arb_pkg::*;
#(
   parameter int ADDR_W        = 24,
   parameter int DATA_W        = 32,
   parameter int MAX_CPU_BURST = 4
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clk_en,
   input  logic              i_p0_req,
   input  logic              i_p0_wr,
   input  logic [ADDR_W-1:0] i_p0_addr,
   input  logic [DATA_W-1:0] i_p0_din,
   output logic              o_p0_ack,
   output logic [DATA_W-1:0] o_p0_dout,
   input  logic              i_p1_req,
   input  logic              i_p1_wr,
   input  logic [ADDR_W-1:0] i_p1_addr,
   input  logic [DATA_W-1:0] i_p1_din,
   output logic              o_p1_ack,
   output logic [DATA_W-1:0] o_p1_dout,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic              o_ram_wr,
   output logic [DATA_W-1:0] o_ram_din,
   input  logic [DATA_W-1:0] i_ram_dout,
   output logic              o_busy
`ifdef DRAM_ARB_MMIO_EN
   ,
   output logic              o_stdout_vld,
   output logic [DATA_W-1:0] o_stdout_data,
   output logic              o_halt
`endif
);

   arb_state_t state, state_nxt;

   logic              any_req;
   logic              req_ok;
   logic              win;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_din;
   logic              win_wr;
   logic              win_mmio;
   logic              halt;

   logic              grant_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic              wr_q;
   logic              mmio_q;
   logic [DATA_W-1:0] p0_dout_q;
   logic [DATA_W-1:0] p1_dout_q;

   dram_arb_pick #(
      .MAX_CPU_BURST(MAX_CPU_BURST)
   ) u_pick (
      .clk     (i_clk),
      .rst     (i_rst),
      .clk_en  (i_clk_en),
      .idle    (state == IDLE),
      .p0_req  (i_p0_req),
      .p1_req  (i_p1_req),
      .halt    (halt),
      .any_req (any_req),
      .winner  (win)
   );

   assign req_ok   = any_req & ~i_rst;
   assign win_addr = (win == P_DMA) ? i_p1_addr : i_p0_addr;
   assign win_din  = (win == P_DMA) ? i_p1_din  : i_p0_din;
   assign win_wr   = (win == P_DMA) ? i_p1_wr   : i_p0_wr;

`ifdef DRAM_ARB_MMIO_EN
   localparam logic [ADDR_W-1:0] STDOUT_A = ~ADDR_W'(1);
   localparam logic [ADDR_W-1:0] HALT_A   = '1;

   logic              stdout_q;
   logic [DATA_W-1:0] stdout_data_q;

   assign win_mmio = (win == P_CPU) && (win_addr == STDOUT_A || win_addr == HALT_A);

   // Halt is sticky until reset; it is raised as soon as the halt write is granted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         halt          <= 1'b0;
         stdout_q      <= 1'b0;
         stdout_data_q <= '0;
      end else if (i_clk_en && state == IDLE && req_ok) begin
         stdout_q <= win_mmio && win_wr && win_addr == STDOUT_A;
         if (win_mmio && win_wr && win_addr == STDOUT_A) begin
            stdout_data_q <= win_din;
         end
         if (win_mmio && win_wr && win_addr == HALT_A) begin
            halt <= 1'b1;
         end
      end
   end

   assign o_stdout_vld  = (state == RESP) && stdout_q;
   assign o_stdout_data = stdout_data_q;
   assign o_halt        = halt;
`else
   assign win_mmio = 1'b0;
   assign halt     = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else if (i_clk_en) begin
         state <= state_nxt;
      end
   end

   // The RAM sees the winner directly in IDLE so it samples on the edge into GRANT.
   always_comb begin
      state_nxt  = state;
      o_busy     = 1'b0;
      o_p0_ack   = 1'b0;
      o_p1_ack   = 1'b0;
      o_ram_addr = addr_q;
      o_ram_din  = din_q;
      o_ram_wr   = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_ok) begin
               state_nxt  = GRANT;
               o_ram_addr = win_addr;
               o_ram_din  = win_din;
               o_ram_wr   = win_wr & ~win_mmio;
            end
         end
         GRANT: begin
            o_busy    = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            o_busy    = 1'b1;
            state_nxt = IDLE;
            o_p0_ack  = (grant_q == P_CPU);
            o_p1_ack  = (grant_q == P_DMA);
         end
         default: begin
            o_busy    = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // Read data is captured at the end of GRANT and held until that port's next read.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         grant_q   <= P_DMA;
         addr_q    <= '0;
         din_q     <= '0;
         wr_q      <= 1'b0;
         mmio_q    <= 1'b0;
         p0_dout_q <= '0;
         p1_dout_q <= '0;
      end else if (i_clk_en) begin
         if (state == IDLE && req_ok) begin
            grant_q <= win;
            addr_q  <= win_addr;
            din_q   <= win_din;
            wr_q    <= win_wr;
            mmio_q  <= win_mmio;
         end
         if (state == GRANT && !wr_q) begin
            if (grant_q == P_CPU) begin
               p0_dout_q <= mmio_q ? '0 : i_ram_dout;
            end else begin
               p1_dout_q <= mmio_q ? '0 : i_ram_dout;
            end
         end
      end
   end

   assign o_p0_dout = p0_dout_q;
   assign o_p1_dout = p1_dout_q;

endmodule
